// File: rtl/stark_mem_dispatch_pkg.sv
// Shared types and default sizing for the memory dispatch stage that sits between the scheduler and the data-cache ports.
package stark_mem_dispatch_pkg;

  localparam int NDATA_PORTS      = 2;
  localparam int MEM_DISP_QDEPTH  = 4;
  localparam int MEM_DISP_MAX_OUT = 4;
  localparam int ROB_ENTRIES      = 32;
  localparam int LSQ_ENTRIES      = 16;

  typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;
  typedef logic [ROB_ENTRIES-1:0]         rob_bitmask_t;
  typedef logic [$clog2(LSQ_ENTRIES)-1:0] lsq_ndx_t;
  typedef logic [31:0]                    physical_address_t;
  typedef logic [63:0]                    mem_data_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_e;

  typedef struct packed {
    lsq_ndx_t          lsq_ndx;
    rob_ndx_t          rndx;
    physical_address_t adr;
    mem_data_t         data;
    mem_size_e         size;
    logic              store;
  } mem_req_t;

  function automatic logic is_stomped(input rob_bitmask_t mask, input rob_ndx_t ndx);
    return mask[ndx];
  endfunction

endpackage

// File: rtl/stark_mem_dispatch_if.sv
// Scheduler/cache-side bundle of the dispatch stage; slave is the dispatch block, master is its environment.
interface stark_mem_dispatch_if #(
  parameter int NPORTS = stark_mem_dispatch_pkg::NDATA_PORTS
);
  logic [NPORTS-1:0]                                sel_v;
  stark_mem_dispatch_pkg::mem_req_t [NPORTS-1:0]    sel_req;
  stark_mem_dispatch_pkg::rob_bitmask_t             robentry_stomp;
  logic [NPORTS-1:0]                                dc_req_v;
  stark_mem_dispatch_pkg::mem_req_t [NPORTS-1:0]    dc_req;
  logic [NPORTS-1:0]                                dc_req_rdy;
  logic [NPORTS-1:0]                                dc_resp_v;
  logic [NPORTS-1:0]                                stall_o;
  logic [NPORTS-1:0]                                drop_v;
  stark_mem_dispatch_pkg::rob_ndx_t [NPORTS-1:0]    drop_rndx;
  logic                                             ovf_o;

  modport master (
    output sel_v, sel_req, robentry_stomp, dc_req_rdy, dc_resp_v,
    input  dc_req_v, dc_req, stall_o, drop_v, drop_rndx, ovf_o
  );

  modport slave (
    input  sel_v, sel_req, robentry_stomp, dc_req_rdy, dc_resp_v,
    output dc_req_v, dc_req, stall_o, drop_v, drop_rndx, ovf_o
  );
endinterface

// File: rtl/stark_mem_dispatch_fifo.sv
// One port's queue: kill-tagged FIFO, stomp scan, drop of killed heads, count and registered stall.
// STARK_MEM_DISPATCH_BYPASS_EN lets a selection into an empty queue present to the cache in the same cycle.
module stark_mem_dispatch_fifo
  import stark_mem_dispatch_pkg::*;
#(
  parameter int QDEPTH = MEM_DISP_QDEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_sel_v,
  input  mem_req_t     i_sel_req,
  input  rob_bitmask_t i_stomp,
  input  logic         i_cnt_ok,
  input  logic         i_dc_rdy,
  output logic         o_dc_req_v,
  output mem_req_t     o_dc_req,
  output logic         o_hs,
  output logic         o_stall,
  output logic         o_drop_v,
  output rob_ndx_t     o_drop_rndx,
  output logic         o_ovf
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(QDEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(QDEPTH - 1);

  mem_req_t          r_mem [QDEPTH];
  logic [QDEPTH-1:0] r_kill;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_stall;

  mem_req_t      w_head;
  logic          w_hvld;
  logic          w_full;
  logic          w_drop;
  logic          w_fifo_req_v;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_n;

  assign w_head = r_mem[r_head];
  assign w_hvld = (r_count != '0);
  assign w_full = (r_count == FULL_CNT);
  assign w_drop = w_hvld & r_kill[r_head];

  // A stomp landing on the presented head withdraws it immediately; the kill bit retires it next cycle.
  assign w_fifo_req_v = w_hvld & ~r_kill[r_head] & i_cnt_ok & ~is_stomped(i_stomp, w_head.rndx);

`ifdef STARK_MEM_DISPATCH_BYPASS_EN
  assign w_byp = ~w_hvld & i_sel_v & i_cnt_ok & ~is_stomped(i_stomp, i_sel_req.rndx);
`else
  assign w_byp = 1'b0;
`endif

  assign o_dc_req_v = w_fifo_req_v | w_byp;
  assign o_dc_req   = w_byp ? i_sel_req : (w_fifo_req_v ? w_head : '0);
  assign o_hs       = o_dc_req_v & i_dc_rdy;

  assign w_pop     = (w_fifo_req_v & i_dc_rdy) | w_drop;
  assign w_push    = i_sel_v & ~w_full & ~(w_byp & i_dc_rdy);
  assign w_count_n = r_count + CW'(w_push) - CW'(w_pop);

  assign o_ovf       = i_sel_v & w_full;
  assign o_drop_v    = w_drop;
  assign o_drop_rndx = w_drop ? w_head.rndx : '0;
  assign o_stall     = r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
      r_kill  <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (is_stomped(i_stomp, r_mem[i].rndx)) r_kill[i] <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_tail]  <= i_sel_req;
        r_kill[r_tail] <= is_stomped(i_stomp, i_sel_req.rndx);
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) r_head <= r_head + PW'(1);
      r_count <= w_count_n;
      r_stall <= (w_count_n >= STALL_CNT);
    end
  end

endmodule

// File: rtl/stark_mem_dispatch.sv
// Per-port buffering between memory scheduler and data-cache ports, with outstanding-request limit and sticky overflow.
// Optional STARK_MEM_DISPATCH_BYPASS_EN: zero-latency presentation of selections that hit an empty queue.
module stark_mem_dispatch
  import stark_mem_dispatch_pkg::*;
#(
  parameter int NPORTS  = NDATA_PORTS,
  parameter int QDEPTH  = MEM_DISP_QDEPTH,
  parameter int MAX_OUT = MEM_DISP_MAX_OUT
) (
  input logic                 clk,
  input logic                 rst,
  stark_mem_dispatch_if.slave bus
);

  localparam int OW = $clog2(MAX_OUT + 1);

  logic [OW-1:0] r_out_cnt [NPORTS];
  logic          r_ovf;

  logic     [NPORTS-1:0] w_cnt_ok;
  logic     [NPORTS-1:0] w_hs;
  logic     [NPORTS-1:0] w_dec;
  logic     [NPORTS-1:0] w_resp_ovf;
  logic     [NPORTS-1:0] w_fifo_ovf;
  logic     [NPORTS-1:0] w_dc_req_v;
  mem_req_t [NPORTS-1:0] w_dc_req;
  logic     [NPORTS-1:0] w_stall;
  logic     [NPORTS-1:0] w_drop_v;
  rob_ndx_t [NPORTS-1:0] w_drop_rndx;

  always_comb begin
    w_cnt_ok   = '0;
    w_dec      = '0;
    w_resp_ovf = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_cnt_ok[p]   = (r_out_cnt[p] < OW'(MAX_OUT));
      w_dec[p]      = bus.dc_resp_v[p] & (r_out_cnt[p] != '0);
      w_resp_ovf[p] = bus.dc_resp_v[p] & (r_out_cnt[p] == '0);
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    stark_mem_dispatch_fifo #(
      .QDEPTH (QDEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_sel_v     (bus.sel_v[p]),
      .i_sel_req   (bus.sel_req[p]),
      .i_stomp     (bus.robentry_stomp),
      .i_cnt_ok    (w_cnt_ok[p]),
      .i_dc_rdy    (bus.dc_req_rdy[p]),
      .o_dc_req_v  (w_dc_req_v[p]),
      .o_dc_req    (w_dc_req[p]),
      .o_hs        (w_hs[p]),
      .o_stall     (w_stall[p]),
      .o_drop_v    (w_drop_v[p]),
      .o_drop_rndx (w_drop_rndx[p]),
      .o_ovf       (w_fifo_ovf[p])
    );
  end

  // Handshake and response in the same cycle cancel; a response with nothing outstanding is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) r_out_cnt[p] <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (w_hs[p] && !w_dec[p])      r_out_cnt[p] <= r_out_cnt[p] + OW'(1);
        else if (!w_hs[p] && w_dec[p]) r_out_cnt[p] <= r_out_cnt[p] - OW'(1);
      end
      if ((|w_fifo_ovf) || (|w_resp_ovf)) r_ovf <= 1'b1;
    end
  end

  assign bus.dc_req_v  = w_dc_req_v;
  assign bus.dc_req    = w_dc_req;
  assign bus.stall_o   = w_stall;
  assign bus.drop_v    = w_drop_v;
  assign bus.drop_rndx = w_drop_rndx;
  assign bus.ovf_o     = r_ovf;

endmodule
